control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardware control unit that drives the datapath's control inputs in place of a bench-scripted T-state sequence.
//  Fetches each instruction (T0-T2), decodes IR, then issues the execute micro-steps.
//  Supported classes: 3-register ALU ops, mul/div (HI/LO), 2-register neg/not, nop and halt.
//  Sits beside the datapath. IR is fed back from the datapath; mem_ready comes from the memory subsystem.
// PARAMETERS
//  NREGS    16  general registers; width of the one-hot Rin/Rout buses
//  OPW      5   opcode width; opcode = IR[31:27]
// PORTS
//  Clock      in   1      single system clock; all state changes on its posedge
//  clear      in   1      reset: synchronous, active-high; sampled on the Clock posedge
//  IR         in   32     instruction register contents; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
//  mem_ready  in   1      memory read data valid; sampled in T1
//  stop       in   1      request halt once the current instruction completes
//  PCout,Zhighout,Zlowout,MDRout,HIout,LOout  out 1 each  bus drive enables
//  PCin,MARin,MDRin,IRin,Yin,Zin,HIin,LOin    out 1 each  register load enables
//  IncPC,Read out  1 each  PC increment / memory read strobe
//  Rin        out  NREGS  one-hot general register load; at most 1 bit set
//  Rout       out  NREGS  one-hot general register bus drive; at most 1 bit set
//  alu_op     out  OPW    ALU operation code; equals IR[31:27] in ALU steps, else 0
//  Run        out  1      high while executing; low in RESET and HALT
// BEHAVIOUR
//  State register (Moore): RESET, T0, T1, T2, T3, T4, T5, T6, HALT.
//  All outputs are combinational decode of state and IR only; no input-to-output paths.
//  clear=1 at a posedge: state<=RESET from any state (including mid-instruction). In RESET all outputs=0, Run=0.
//  RESET->T0 on the first posedge with clear=0.
//  Step actions (unlisted outputs are 0):
//   T0: PCout,MARin,IncPC,Zin.
//   T1: Zlowout,PCin,Read,MDRin. Stays in T1 while mem_ready=0; PCin asserted on the first T1 cycle only.
//   T2: MDRout,IRin. Decode happens in T3 using the loaded IR.
//   ALU3 {00011 add,00100 sub,00101 and,00110 or,00111 shr,01000 shra,01001 shl,01010 ror,01011 rol}:
//    T3: Rout[Rb],Yin.  T4: Rout[Rc],alu_op,Zin.  T5: Zlowout,Rin[Ra].  ->T0
//   MULDIV {01111 mul,10000 div}:
//    T3: Rout[Ra],Yin.  T4: Rout[Rb],alu_op,Zin.  T5: Zlowout,LOin.  T6: Zhighout,HIin.  ->T0
//   UNARY {10001 neg,10010 not}: T3: Rout[Rb],alu_op,Zin.  T4: Zlowout,Rin[Ra].  ->T0
//   11010 nop and any undefined opcode: T3 with no outputs asserted ->T0.
//   11011 halt: T3 ->HALT.
//  HALT: all outputs 0, Run=0; only clear exits.
//  stop: latched into stop_pend while Run=1. At the final step of an instruction, next state=HALT instead of T0.
//   stop_pend is cleared by clear. stop asserted during T0 lets that instruction complete, then halts.
//  Rin/Rout decode uses the 4-bit field modulo NREGS. Ra=Rb is legal (e.g. neg R2,R2).
//  alu_op=0 outside the steps marked alu_op.
//  Run=1 in T0..T6.
//  Simultaneous clear and stop: clear wins; stop_pend=0.
// TESTING
//  1 Reset: hold clear for 2 cycles mid-T4 -> next state RESET, every output 0, Run=0; T0 on the cycle after release.
//  2 Fetch: mem_ready low for 3 cycles in T1 -> T1 held 4 cycles, PCin for 1 cycle, Read high throughout, IRin 1 cycle.
//  3 ALU3: IR=0x28918000 (and R1,R2,R3) -> T3 Rout=0x0004,Yin; T4 Rout=0x0008,alu_op=00101; T5 Rin=0x0002.
//  4 MULDIV: IR=0x79180000 (mul R2,R3) -> T3 Rout=0x0004; T4 Rout=0x0008,alu_op=01111; T5 LOin; T6 HIin,Zhighout; then T0.
//  5 Shra: IR opcode 01000, Ra=R1,Rb=R3,Rc=R5 -> T4 Rout=0x0020,alu_op=01000; T5 Zlowout,Rin=0x0002.
//  6 Halt/stop: IR=0xD8000000 -> HALT, Run=0, outputs frozen at 0; and stop pulsed in T3 of add -> add completes then HALT.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit.
// Moore FSM driving the datapath's bus-drive and register-load enables
// from the current T-state and the instruction register.
module control_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             HIout,
    output logic             LOout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic             Read,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [OPW-1:0]   alu_op,
    output logic             Run
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_done;        // where the last execute step goes
    logic             r_t1_held;     // already spent a cycle in T1 waiting on memory
    logic             r_stop_pend;   // halt requested, honoured at end of instruction
    logic [4:0]       w_opc;
    logic [OPW-1:0]   w_op;
    logic             w_alu3, w_muldiv, w_unary, w_halt;
    logic [NREGS-1:0] w_oh_ra, w_oh_rb, w_oh_rc;

    // Register fields index the one-hot buses modulo the register count.
    function automatic logic [NREGS-1:0] f_onehot(input logic [3:0] f);
        return NREGS'(1) << (32'(f) % NREGS);
    endfunction

    assign w_opc   = IR[31:27];
    assign w_op    = IR[31 -: OPW];
    assign w_oh_ra = f_onehot(IR[26:23]);
    assign w_oh_rb = f_onehot(IR[22:19]);
    assign w_oh_rc = f_onehot(IR[18:15]);
    // A pending or same-cycle stop request turns the final step into a halt.
    assign w_done  = (r_stop_pend || stop) ? S_HALT : S_T0;

    // Opcode class decode; nop and undefined opcodes fall into no class.
    always_comb begin
        w_alu3   = 1'b0;
        w_muldiv = 1'b0;
        w_unary  = 1'b0;
        w_halt   = 1'b0;
        case (w_opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: w_alu3   = 1'b1;
            5'b01111, 5'b10000:                     w_muldiv = 1'b1;
            5'b10001, 5'b10010:                     w_unary  = 1'b1;
            5'b11011:                               w_halt   = 1'b1;
            default: ;
        endcase
    end

    // State register plus the T1-wait and stop-pending flags; clear wins over everything.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state     <= S_RESET;
            r_t1_held   <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_t1_held <= (r_state == S_T1) && !mem_ready;
            if (Run && stop)
                r_stop_pend <= 1'b1;
        end
    end

    // Next-state and Moore output decode from state and IR.
    always_comb begin
        w_next   = r_state;
        PCout    = 1'b0;  Zhighout = 1'b0;  Zlowout = 1'b0;  MDRout = 1'b0;
        HIout    = 1'b0;  LOout    = 1'b0;  PCin    = 1'b0;  MARin  = 1'b0;
        MDRin    = 1'b0;  IRin     = 1'b0;  Yin     = 1'b0;  Zin    = 1'b0;
        HIin     = 1'b0;  LOin     = 1'b0;  IncPC   = 1'b0;  Read   = 1'b0;
        Rin      = '0;
        Rout     = '0;
        alu_op   = '0;
        Run      = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin    = !r_t1_held;
                w_next  = mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_alu3) begin
                    Rout = w_oh_rb; Yin = 1'b1; w_next = S_T4;
                end else if (w_muldiv) begin
                    Rout = w_oh_ra; Yin = 1'b1; w_next = S_T4;
                end else if (w_unary) begin
                    Rout = w_oh_rb; alu_op = w_op; Zin = 1'b1; w_next = S_T4;
                end else if (w_halt) begin
                    w_next = S_HALT;
                end else begin
                    w_next = w_done;
                end
            end
            S_T4: begin
                if (w_alu3) begin
                    Rout = w_oh_rc; alu_op = w_op; Zin = 1'b1; w_next = S_T5;
                end else if (w_muldiv) begin
                    Rout = w_oh_rb; alu_op = w_op; Zin = 1'b1; w_next = S_T5;
                end else if (w_unary) begin
                    Zlowout = 1'b1; Rin = w_oh_ra; w_next = w_done;
                end else begin
                    w_next = w_done;
                end
            end
            S_T5: begin
                if (w_alu3) begin
                    Zlowout = 1'b1; Rin = w_oh_ra; w_next = w_done;
                end else if (w_muldiv) begin
                    Zlowout = 1'b1; LOin = 1'b1; w_next = S_T6;
                end else begin
                    w_next = w_done;
                end
            end
            S_T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                w_next   = w_done;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a step-count model with a
// micro-op table is compared against the DUT every cycle, and literal
// expectations pin the key steps of each test scenario.
module tb_control_sequencer;

    localparam int NREGS = 16;
    localparam int OPW   = 5;

    localparam logic [15:0] C_PCOUT  = 16'h8000, C_ZHI   = 16'h4000, C_ZLO   = 16'h2000,
                            C_MDROUT = 16'h1000, C_PCIN  = 16'h0200, C_MARIN = 16'h0100,
                            C_MDRIN  = 16'h0080, C_IRIN  = 16'h0040, C_YIN   = 16'h0020,
                            C_ZIN    = 16'h0010, C_HIIN  = 16'h0008, C_LOIN  = 16'h0004,
                            C_INCPC  = 16'h0002, C_READ  = 16'h0001;

    logic Clock = 1'b0;
    logic clear, mem_ready, stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin;
    logic MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Run;
    logic [NREGS-1:0] Rin, Rout;
    logic [OPW-1:0]   alu_op;

    control_sequencer #(.NREGS(NREGS), .OPW(OPW)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    logic [53:0] dut_vec;
    assign dut_vec = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, PCin, MARin,
                      MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read,
                      Rin, Rout, alu_op, Run};

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- model ----------------
    // mode 0 = reset, 1 = running, 2 = halted; m_t = T-step number.
    typedef struct {
        logic [15:0] ctl;
        int          rout;   // 0 none, 1 Ra, 2 Rb, 3 Rc
        int          rin;
        bit          alu;
    } micro_t;

    int m_mode = 0;
    int m_t    = 0;
    bit m_t1f  = 1'b0;
    bit m_pend = 1'b0;
    int m_c;

    // 0 alu3, 1 muldiv, 2 unary, 3 nop/undefined, 4 halt
    function automatic int cls_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 0;
        if (op == 5'd15 || op == 5'd16) return 1;
        if (op == 5'd17 || op == 5'd18) return 2;
        if (op == 5'd27) return 4;
        return 3;
    endfunction

    function automatic int len_of(input int c);
        case (c)
            0: return 3;
            1: return 4;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] field_oh(input logic [31:0] ir, input int sel);
        case (sel)
            1: return 16'd1 << ir[26:23];
            2: return 16'd1 << ir[22:19];
            3: return 16'd1 << ir[18:15];
            default: return 16'd0;
        endcase
    endfunction

    // Execute micro-op table indexed by class and step within execute.
    function automatic micro_t micro(input int c, input int k);
        micro_t u;
        u = '{16'h0, 0, 0, 1'b0};
        if (c == 0 && k == 0) u = '{C_YIN,         2, 0, 1'b0};
        if (c == 0 && k == 1) u = '{C_ZIN,         3, 0, 1'b1};
        if (c == 0 && k == 2) u = '{C_ZLO,         0, 1, 1'b0};
        if (c == 1 && k == 0) u = '{C_YIN,         1, 0, 1'b0};
        if (c == 1 && k == 1) u = '{C_ZIN,         2, 0, 1'b1};
        if (c == 1 && k == 2) u = '{C_ZLO | C_LOIN, 0, 0, 1'b0};
        if (c == 1 && k == 3) u = '{C_ZHI | C_HIIN, 0, 0, 1'b0};
        if (c == 2 && k == 0) u = '{C_ZIN,         2, 0, 1'b1};
        if (c == 2 && k == 1) u = '{C_ZLO,         0, 1, 1'b0};
        return u;
    endfunction

    function automatic logic [53:0] exp_vec();
        micro_t u;
        logic [15:0] ctl, rin, rout;
        logic [4:0]  alu;
        ctl = 16'h0; rin = 16'h0; rout = 16'h0; alu = 5'd0;
        if (m_mode != 1) return 54'd0;
        u = micro(cls_of(IR[31:27]), m_t - 3);
        case (m_t)
            0: ctl = C_PCOUT | C_MARIN | C_INCPC | C_ZIN;
            1: ctl = C_ZLO | C_READ | C_MDRIN | (m_t1f ? C_PCIN : 16'h0);
            2: ctl = C_MDROUT | C_IRIN;
            default: begin
                ctl  = u.ctl;
                rin  = field_oh(IR, u.rin);
                rout = field_oh(IR, u.rout);
                alu  = u.alu ? IR[31:27] : 5'd0;
            end
        endcase
        return {ctl, rin, rout, alu, 1'b1};
    endfunction

    always @(posedge Clock) begin
        if (clear) begin
            m_mode = 0;
            m_pend = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_t    = 0;
        end else if (m_mode == 1) begin
            m_c = cls_of(IR[31:27]);
            if (m_t == 0) begin
                m_t = 1; m_t1f = 1'b1;
            end else if (m_t == 1) begin
                if (mem_ready) m_t = 2;
                else m_t1f = 1'b0;
            end else if (m_t == 2) begin
                m_t = 3;
            end else if (m_c == 4) begin
                m_mode = 2;
            end else if (m_t - 3 == len_of(m_c) - 1) begin
                if (m_pend || stop) m_mode = 2;
                else m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
            if (stop) m_pend = 1'b1;
        end
    end

    always @(negedge Clock)
        if (cmp_en) chk("cycle", 64'(dut_vec), 64'(exp_vec()));

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic wait_t(input int tgt);
        int n = 0;
        while (!(m_mode == 1 && m_t == tgt) && n < 40) begin
            tick();
            n++;
        end
        if (!(m_mode == 1 && m_t == tgt)) begin
            n_vec++; n_err++;
            $display("FAIL wait_T%0d: timed out, model mode %0d step %0d", tgt, m_mode, m_t);
        end
    endtask

    task automatic wait_halt();
        int n = 0;
        while (m_mode != 2 && n < 40) begin
            tick();
            n++;
        end
        if (m_mode != 2) begin
            n_vec++; n_err++;
            $display("FAIL wait_halt: timed out, model mode %0d", m_mode);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    int pc_cnt, rd_cnt;

    initial begin
        clear = 1'b1; stop = 1'b0; mem_ready = 1'b1; IR = 32'h0;
        tick(); tick();
        cmp_en = 1'b1;
        #1 chk("reset_outs", 64'(dut_vec), 64'd0);

        // Fetch with memory stall, executing add R1,R2,R3
        IR = mk(5'b00011, 4'd1, 4'd2, 4'd3); mem_ready = 1'b0; clear = 1'b0;
        tick();
        #1 chk("t0_ctl", 64'({PCout, MARin, IncPC, Zin, Run}), 64'(5'b11111));
        tick();
        pc_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1 pc_cnt += int'(PCin); rd_cnt += int'(Read);
            tick();
        end
        chk("t1_pcin_cycles", 64'(pc_cnt), 64'd1);
        chk("t1_read_cycles", 64'(rd_cnt), 64'd4);
        #1 chk("t2_irin", 64'({MDRout, IRin, Read}), 64'(3'b110));

        // and R1,R2,R3
        wait_t(0); IR = 32'h28918000;
        wait_t(3);
        #1 chk("and_t3", 64'({Rout, Yin}), 64'({16'h0004, 1'b1}));
        tick(); #1 chk("and_t4", 64'({Rout, alu_op, Zin}), 64'({16'h0008, 5'b00101, 1'b1}));
        tick(); #1 chk("and_t5", 64'({Rin, Zlowout}), 64'({16'h0002, 1'b1}));

        // mul R2,R3
        wait_t(0); IR = 32'h79180000;
        wait_t(3);
        #1 chk("mul_t3", 64'({Rout, Yin}), 64'({16'h0004, 1'b1}));
        tick(); #1 chk("mul_t4", 64'({Rout, alu_op}), 64'({16'h0008, 5'b01111}));
        tick(); #1 chk("mul_t5", 64'({LOin, Zlowout, HIin}), 64'(3'b110));
        tick(); #1 chk("mul_t6", 64'({HIin, Zhighout, LOin}), 64'(3'b110));
        tick(); #1 chk("mul_next_t0", 64'({PCout, Run}), 64'(2'b11));

        // shra R1,R3,R5
        wait_t(0); IR = mk(5'b01000, 4'd1, 4'd3, 4'd5);
        wait_t(4);
        #1 chk("shra_t4", 64'({Rout, alu_op}), 64'({16'h0020, 5'b01000}));
        tick(); #1 chk("shra_t5", 64'({Zlowout, Rin}), 64'({1'b1, 16'h0002}));

        // neg R2,R2
        wait_t(0); IR = mk(5'b10001, 4'd2, 4'd2, 4'd0);
        wait_t(3);
        #1 chk("neg_t3", 64'({Rout, alu_op, Zin}), 64'({16'h0004, 5'b10001, 1'b1}));
        tick(); #1 chk("neg_t4", 64'({Rin, Zlowout}), 64'({16'h0004, 1'b1}));

        // nop, then an undefined opcode
        wait_t(0); IR = mk(5'b11010, 4'd0, 4'd0, 4'd0);
        wait_t(3); tick();
        #1 chk("nop_back_t0", 64'({PCout, Run}), 64'(2'b11));
        IR = mk(5'b11111, 4'd7, 4'd7, 4'd7);
        wait_t(3); tick();
        wait_t(0);

        // clear held two cycles in the middle of T4
        IR = mk(5'b00011, 4'd4, 4'd5, 4'd6);
        wait_t(4);
        clear = 1'b1;
        tick(); #1 chk("clr_outs", 64'(dut_vec), 64'd0);
        tick(); clear = 1'b0;
        tick(); #1 chk("clr_t0", 64'({PCout, Run}), 64'(2'b11));

        // stop during T0: or R7,R8,R9 completes, then halt
        IR = mk(5'b00110, 4'd7, 4'd8, 4'd9); stop = 1'b1;
        tick(); stop = 1'b0;
        wait_halt();
        #1 chk("stop_t0_halt", 64'(dut_vec), 64'd0);
        mem_ready = 1'b0; tick(); tick(); mem_ready = 1'b1;

        // clear and stop together: stop is dropped
        clear = 1'b1; stop = 1'b1; tick();
        clear = 1'b0; stop = 1'b0;
        IR = mk(5'b00011, 4'd1, 4'd1, 4'd1);
        wait_t(3);
        // stop pulsed in T3 of add: add completes, then halt
        stop = 1'b1; tick(); stop = 1'b0;
        tick(); #1 chk("stop_t3_t5", 64'({Rin, Zlowout}), 64'({16'h0002, 1'b1}));
        tick(); #1 chk("stop_t3_halt", 64'(dut_vec), 64'd0);

        // halt instruction
        clear = 1'b1; tick(); clear = 1'b0;
        IR = 32'hD8000000;
        wait_t(3); tick();
        #1 chk("halt_run", 64'(Run), 64'd0);
        stop = 1'b1; mem_ready = 1'b0; tick(); tick();
        stop = 1'b0; mem_ready = 1'b1; tick();
        #1 chk("halt_frozen", 64'(dut_vec), 64'd0);

        clear = 1'b1; tick(); tick();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
